// File: rtl/mult8_seq_arb.sv
// Two-requester 8x8 unsigned multiplier built on a shared external 4x4 multiplier.
// Four nibble partial products are accumulated over four cycles, then the result is held until taken.
module mult8_seq_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [3:0]  mm_a,
  output logic [3:0]  mm_b,
  input  logic [7:0]  mm_p,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_p,
  output logic        rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        id_q;
  logic [15:0] acc;
  logic        rr_ptr;

  logic        gnt_id;
  logic        accept;
  logic [15:0] partial;

  // Arbitration: ready is combinational so the requester sees the grant in the same cycle.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = RR_EN ? rr_ptr : 1'b0;
    end else begin
      gnt_id = req1_valid;
    end
    req0_ready = (state == IDLE) && req0_valid && !gnt_id;
    req1_ready = (state == IDLE) && req1_valid && gnt_id;
    accept     = req0_ready || req1_ready;
  end

  // Nibble selection: step[1] picks the A nibble, step[0] the B nibble.
  always_comb begin
    mm_a    = 4'h0;
    mm_b    = 4'h0;
    partial = 16'h0000;
    if (state == CALC) begin
      mm_a = step[1] ? a_q[7:4] : a_q[3:0];
      mm_b = step[0] ? b_q[7:4] : b_q[3:0];
      case (step)
        2'd0:    partial = 16'(mm_p);
        2'd1,
        2'd2:    partial = 16'(mm_p) << 4;
        default: partial = 16'(mm_p) << 8;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      id_q      <= 1'b0;
      acc       <= 16'h0000;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_p     <= 16'h0000;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= gnt_id ? req1_a : req0_a;
            b_q   <= gnt_id ? req1_b : req0_b;
            id_q  <= gnt_id;
            acc   <= 16'h0000;
            step  <= 2'd0;
            state <= CALC;
            if (RR_EN) begin
              rr_ptr <= ~gnt_id;
            end
          end
        end
        CALC: begin
          acc  <= acc + partial;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            rsp_p     <= acc + partial;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_arb.sv
// Bench for mult8_seq_arb: a round-robin and a fixed-priority instance share all stimulus;
// a transaction-timeline model is compared every cycle, plus hand-computed literal checks.
module tb_mult8_seq_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, v1;
  logic [7:0] a0, b0, a1, b1;
  logic       rsp_ready;

  logic        r0_rdy [2];
  logic        r1_rdy [2];
  logic [3:0]  mma    [2];
  logic [3:0]  mmb    [2];
  logic [7:0]  mmp    [2];
  logic        rv     [2];
  logic [15:0] rp     [2];
  logic        rid    [2];

  // External shared 4x4 multipliers, one per instance.
  assign mmp[0] = {4'h0, mma[0]} * {4'h0, mmb[0]};
  assign mmp[1] = {4'h0, mmb[1]} * {4'h0, mma[1]};

  mult8_seq_arb #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0_rdy[0]), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1_rdy[0]), .req1_a(a1), .req1_b(b1),
    .mm_a(mma[0]), .mm_b(mmb[0]), .mm_p(mmp[0]),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_p(rp[0]), .rsp_id(rid[0])
  );

  mult8_seq_arb #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0_rdy[1]), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1_rdy[1]), .req1_a(a1), .req1_b(b1),
    .mm_a(mma[1]), .mm_b(mmb[1]), .mm_p(mmp[1]),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_p(rp[1]), .rsp_id(rid[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: ph = 0 idle, 1..4 = partial-product cycle ph-1, 5 = holding the result.
  int         ph   [2];
  logic [7:0] ma   [2];
  logic [7:0] mb   [2];
  logic       mid  [2];
  logic       mptr [2];

  // Which requester instance k serves given the current valids (k=0 round-robin, k=1 fixed).
  function automatic logic pick(input int k, input logic p);
    if (v0 && v1) return (k == 0) ? p : 1'b0;
    return v1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k]   <= 0;
        mptr[k] <= 1'b0;
      end else if (ph[k] == 0) begin
        if (v0 || v1) begin
          ma[k]  <= pick(k, mptr[k]) ? a1 : a0;
          mb[k]  <= pick(k, mptr[k]) ? b1 : b0;
          mid[k] <= pick(k, mptr[k]);
          if (k == 0) mptr[k] <= ~pick(k, mptr[k]);
          ph[k]  <= 1;
        end
      end else if (ph[k] < 5) begin
        ph[k] <= ph[k] + 1;
      end else if (rsp_ready) begin
        ph[k] <= 0;
      end
    end
  end

  // Observed grants and delivered response ids per instance.
  bit g_rr[$];
  bit g_fp[$];
  bit id_rr[$];
  bit id_fp[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (r0_rdy[0] && v0) g_rr.push_back(1'b0);
      if (r1_rdy[0] && v1) g_rr.push_back(1'b1);
      if (r0_rdy[1] && v0) g_fp.push_back(1'b0);
      if (r1_rdy[1] && v1) g_fp.push_back(1'b1);
      if (rv[0] && rsp_ready) id_rr.push_back(rid[0]);
      if (rv[1] && rsp_ready) id_fp.push_back(rid[1]);
    end
  end

  logic [3:0] ea, eb;
  logic       e_r0, e_r1;
  int         s;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e_r0 = (ph[k] == 0) && v0 && !pick(k, mptr[k]);
        e_r1 = (ph[k] == 0) && v1 && pick(k, mptr[k]);
        check($sformatf("req0_ready[%0d]", k), r0_rdy[k], e_r0);
        check($sformatf("req1_ready[%0d]", k), r1_rdy[k], e_r1);
        ea = 4'h0;
        eb = 4'h0;
        if (ph[k] >= 1 && ph[k] <= 4) begin
          s  = ph[k] - 1;
          ea = (s >= 2) ? ma[k][7:4] : ma[k][3:0];
          eb = (s % 2 == 1) ? mb[k][7:4] : mb[k][3:0];
        end
        check($sformatf("mm_a[%0d]", k), mma[k], ea);
        check($sformatf("mm_b[%0d]", k), mmb[k], eb);
        check($sformatf("rsp_valid[%0d]", k), rv[k], ph[k] == 5);
        if (ph[k] == 5) begin
          check($sformatf("rsp_p[%0d]", k), rp[k], {8'h00, ma[k]} * {8'h00, mb[k]});
          check($sformatf("rsp_id[%0d]", k), rid[k], mid[k]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance 0 with a hand-computed product; bounded waits.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p);
    bit ok;
    ok = 1'b0;
    if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
    else    begin v0 = 1'b1; a0 = a; b0 = b; end
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      ok = (id ? r1_rdy[0] : r0_rdy[0]) === 1'b1;
      if (!ok) tick;
    end
    check("op_accept", ok, 1);
    tick;
    v0 = 1'b0;
    v1 = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      ok = rv[0] === 1'b1;
      if (!ok) tick;
    end
    check("op_rsp_seen", ok, 1);
    check("op_rsp_p", rp[0], exp_p);
    check("op_rsp_id", rid[0], id);
    tick;
  endtask

  logic [3:0] lit_a [4];
  logic [3:0] lit_b [4];
  int         n0;

  initial begin
    lit_a = '{4'hC, 4'hC, 4'h3, 4'h3};
    lit_b = '{4'h5, 4'hA, 4'h5, 4'hA};
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    rsp_ready = 1'b1;

    tick;
    chk_en = 1'b1;
    tick;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_rsp_valid[%0d]", k), rv[k], 0);
      check($sformatf("reset_rsp_p[%0d]", k), rp[k], 0);
      check($sformatf("reset_rsp_id[%0d]", k), rid[k], 0);
      check($sformatf("reset_mm_a[%0d]", k), mma[k], 0);
      check($sformatf("reset_mm_b[%0d]", k), mmb[k], 0);
    end

    // FF*FF on requester 0, response exactly four edges after accept.
    tick;
    rst_n = 1'b1; v0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
    @(negedge clk);
    check("ff_ready0", r0_rdy[0], 1);
    tick;
    v0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      @(negedge clk);
      check($sformatf("ff_latency_edge%0d", i), rv[0], (i == 4) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ff_rsp_p[%0d]", k), rp[k], 16'hFE01);
      check($sformatf("ff_rsp_id[%0d]", k), rid[k], 0);
    end
    tick;

    // 3C*A5 on requester 1, nibble sequence pinned.
    v1 = 1'b1; a1 = 8'h3C; b1 = 8'hA5;
    tick;
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("seq_mm_a_step%0d", i), mma[0], lit_a[i]);
      check($sformatf("seq_mm_b_step%0d", i), mmb[0], lit_b[i]);
      tick;
    end
    @(negedge clk);
    check("seq_rsp_valid", rv[0], 1);
    check("seq_rsp_p", rp[0], 16'h26AC);
    check("seq_rsp_id", rid[0], 1);
    tick;

    run_op(1'b0, 8'h00, 8'hFF, 16'h0000);
    run_op(1'b1, 8'h01, 8'h01, 16'h0001);
    run_op(1'b0, 8'h80, 8'h02, 16'h0100);
    run_op(1'b1, 8'hF0, 8'h0F, 16'h0E10);

    // Both requesters valid continuously from reset.
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    g_rr.delete(); g_fp.delete(); id_rr.delete(); id_fp.delete();
    v0 = 1'b1; v1 = 1'b1;
    a0 = 8'h12; b0 = 8'h34; a1 = 8'hAB; b1 = 8'hCD;
    repeat (24) tick;
    v0 = 1'b0; v1 = 1'b0;
    tick;
    check("rr_grant_count", g_rr.size(), 4);
    check("rr_rsp_count", id_rr.size(), 4);
    check("fp_grant_count", g_fp.size(), 4);
    for (int i = 0; i < 4 && i < g_rr.size(); i++)
      check($sformatf("rr_grant%0d", i), g_rr[i], i % 2);
    for (int i = 0; i < 4 && i < id_rr.size(); i++)
      check($sformatf("rr_rsp_id%0d", i), id_rr[i], i % 2);
    for (int i = 0; i < 4 && i < g_fp.size(); i++)
      check($sformatf("fp_grant%0d", i), g_fp[i], 0);
    for (int i = 0; i < id_fp.size(); i++)
      check($sformatf("fp_rsp_id%0d", i), id_fp[i], 0);

    // Consumer stalls three cycles in DONE while both requesters wait.
    rsp_ready = 1'b0;
    v0 = 1'b1; a0 = 8'h07; b0 = 8'h09;
    tick;
    v0 = 1'b0;
    repeat (4) tick;
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rsp_valid", i), rv[0], 1);
      check($sformatf("stall%0d_rsp_p", i), rp[0], 16'h003F);
      check($sformatf("stall%0d_rsp_id", i), rid[0], 0);
      check($sformatf("stall%0d_ready0", i), r0_rdy[0], 0);
      check($sformatf("stall%0d_ready1", i), r1_rdy[0], 0);
      tick;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", rv[0], 1);
    tick;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    check("stall_after_release", rv[0], 0);
    tick;

    // Reset while in partial-product cycle 2 discards the operation.
    n0 = id_rr.size();
    v1 = 1'b1; a1 = 8'h5A; b1 = 8'hC3;
    tick;
    v1 = 1'b0;
    tick;
    tick;
    @(negedge clk);
    check("midreset_step2_mm_a", mma[0], 4'h5);
    check("midreset_step2_mm_b", mmb[0], 4'h3);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_rsp_valid", rv[0], 0);
    check("midreset_mm_a", mma[0], 0);
    repeat (10) tick;
    check("midreset_no_rsp", id_rr.size(), n0);
    run_op(1'b0, 8'h10, 8'h10, 16'h0100);

    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
